// File: rtl/actor_trigger_ctrl_if.sv
// Signal bundle between one actor trigger and its surroundings: the
// network control handshake, the actor core handshake and the peer
// synchronisation wires. The trigger uses the slave view and whatever
// drives it (network glue or a bench) uses the master view.
interface actor_trigger_ctrl_if;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic        ap_ready;
  logic        actor_start;
  logic        actor_done;
  logic [31:0] actor_return;
  logic        all_sleep;
  logic        all_sync_done;
  logic        any_sync_exec;
  logic        sleep;
  logic        sync_done;
  logic        sync_exec;
  logic [2:0]  state_out;

  modport master (
    output ap_start, actor_done, actor_return,
           all_sleep, all_sync_done, any_sync_exec,
    input  ap_idle, ap_done, ap_ready, actor_start,
           sleep, sync_done, sync_exec, state_out
  );

  modport slave (
    input  ap_start, actor_done, actor_return,
           all_sleep, all_sync_done, any_sync_exec,
    output ap_idle, ap_done, ap_ready, actor_start,
           sleep, sync_done, sync_exec, state_out
  );
endinterface

// File: rtl/actor_trigger_ctrl.sv
// Per-actor trigger: repeatedly launches one HLS actor, puts it to sleep
// when it stops making progress, and joins a network-wide sync round to
// decide whether the whole dataflow network has gone quiet.
module actor_trigger_ctrl #(
  parameter logic [15:0] SLEEP_TIMEOUT = 16'd64,
  parameter int          TIMER_WIDTH   = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  actor_trigger_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE_STATE  = 3'd0,
    LAUNCH      = 3'd1,
    CHECK       = 3'd2,
    SLEEP       = 3'd3,
    SYNC_LAUNCH = 3'd4,
    SYNC_CHECK  = 3'd5,
    SYNC_WAIT   = 3'd6,
    SYNC_EXEC   = 3'd7
  } state_t;

  localparam logic [1:0] RET_IDLE = 2'd0;
  localparam logic [1:0] RET_WAIT = 2'd1;
  localparam logic [1:0] RET_TEST = 2'd2;
  localparam logic [1:0] RET_EXEC = 2'd3;

  localparam logic [TIMER_WIDTH-1:0] TIMEOUT = TIMER_WIDTH'(SLEEP_TIMEOUT);

  state_t                  state_q, state_d;
  logic [TIMER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]              ret_q, ret_d;
  logic                    flag_q, flag_d;
  logic                    done_q, done_d;
  logic [1:0]              ret_code;

  // Fold out-of-range return codes onto WAIT so the rest of the logic
  // only ever sees the four defined codes.
  always_comb begin
    ret_code = RET_WAIT;
    if (bus.actor_return <= 32'd3) begin
      ret_code = bus.actor_return[1:0];
    end
  end

  // Next-state logic plus updates of the sleep counter, the registered
  // return code, the sync-progress flag and the quiescence pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE_STATE: begin
        if (bus.ap_start) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (bus.actor_done && ret_code != RET_EXEC) begin
          ret_d   = ret_code;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (ret_q == RET_TEST) begin
          state_d = LAUNCH;
        end else begin
          cnt_d   = '0;
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (bus.all_sleep) begin
          state_d = SYNC_LAUNCH;
        end else if (cnt_q == TIMEOUT) begin
          state_d = LAUNCH;
        end
      end
      SYNC_LAUNCH: begin
        if (bus.actor_done) begin
          flag_d  = (ret_code == RET_EXEC);
          state_d = SYNC_CHECK;
        end
      end
      SYNC_CHECK: begin
        state_d = flag_q ? SYNC_EXEC : SYNC_WAIT;
      end
      SYNC_EXEC: begin
        if (bus.all_sync_done) state_d = LAUNCH;
      end
      SYNC_WAIT: begin
        if (bus.all_sync_done) begin
          if (bus.any_sync_exec) begin
            state_d = LAUNCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE_STATE;
          end
        end
      end
      default: state_d = IDLE_STATE;
    endcase
  end

  // State and bookkeeping registers; reset aborts any invocation in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE_STATE;
      cnt_q   <= '0;
      ret_q   <= RET_IDLE;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign bus.ap_idle     = (state_q == IDLE_STATE);
  assign bus.ap_done     = done_q;
  assign bus.ap_ready    = done_q;
  assign bus.actor_start = (state_q == LAUNCH) || (state_q == SYNC_LAUNCH);
  assign bus.sleep       = (state_q == SLEEP);
  assign bus.sync_done   = (state_q == SYNC_WAIT) || (state_q == SYNC_EXEC);
  assign bus.sync_exec   = (state_q == SYNC_EXEC);
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_actor_trigger_ctrl.sv
// Directed bench for actor_trigger_ctrl: walks the trigger through the
// launch, sleep, sync and reset scenarios cycle by cycle against
// hand-computed state and output values.
module tb_actor_trigger_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_SLEEP  = 3'd3;
  localparam logic [2:0] S_SLNCH  = 3'd4;
  localparam logic [2:0] S_SCHK   = 3'd5;
  localparam logic [2:0] S_SWAIT  = 3'd6;
  localparam logic [2:0] S_SEXEC  = 3'd7;

  logic ap_clk;
  logic ap_rst_n;
  int   check_count;
  int   pass_count;

  actor_trigger_ctrl_if bus ();

  actor_trigger_ctrl #(
    .SLEEP_TIMEOUT (16'd4),
    .TIMER_WIDTH   (16)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      pass_count++;
    end
  endtask

  task automatic applyStimulus(input logic start, input logic done,
                               input logic [31:0] ret, input logic all_slp,
                               input logic all_sdone, input logic any_sexec);
    bus.ap_start      = start;
    bus.actor_done    = done;
    bus.actor_return  = ret;
    bus.all_sleep     = all_slp;
    bus.all_sync_done = all_sdone;
    bus.any_sync_exec = any_sexec;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic expectState(input string tag, input logic [2:0] st,
                             input logic start);
    checkOutput({tag, "_state"}, 32'(bus.state_out), 32'(st));
    checkOutput({tag, "_actor_start"}, 32'(bus.actor_start), 32'(start));
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    ap_rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset values
    expectState("rst", S_IDLE, 1'b0);
    checkOutput("rst_ap_idle", 32'(bus.ap_idle), 32'd1);
    checkOutput("rst_ap_done", 32'(bus.ap_done), 32'd0);
    checkOutput("rst_ap_ready", 32'(bus.ap_ready), 32'd0);
    checkOutput("rst_sleep", 32'(bus.sleep), 32'd0);
    checkOutput("rst_sync_done", 32'(bus.sync_done), 32'd0);
    checkOutput("rst_sync_exec", 32'(bus.sync_exec), 32'd0);
    ap_rst_n = 1'b1;
    tick();
    expectState("idle_hold", S_IDLE, 1'b0);

    // Three back-to-back EXECUTED invocations, then WAIT, sleep, relaunch
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("launch0", S_LAUNCH, 1'b1);
    checkOutput("launch0_ap_idle", 32'(bus.ap_idle), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectState($sformatf("exec%0d", i), S_LAUNCH, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("wait_check", S_CHECK, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectState($sformatf("sleep%0d", i), S_SLEEP, 1'b0);
      checkOutput($sformatf("sleep%0d_out", i), 32'(bus.sleep), 32'd1);
    end
    tick();
    expectState("timeout_relaunch", S_LAUNCH, 1'b1);

    // TEST return: one actor_start-low cycle, then relaunch
    applyStimulus(1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("test_check", S_CHECK, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("test_relaunch", S_LAUNCH, 1'b1);

    // all_sleep coinciding with timeout; sync WAIT; network quiesces
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("q_sleep_enter", S_SLEEP, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    expectState("q_sleep_at_timeout", S_SLEEP, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    expectState("q_sync_launch", S_SLNCH, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("q_sync_check", S_SCHK, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("q_sync_wait", S_SWAIT, 1'b0);
    checkOutput("q_sync_done", 32'(bus.sync_done), 32'd1);
    checkOutput("q_sync_exec", 32'(bus.sync_exec), 32'd0);
    tick();
    expectState("q_sync_wait_hold", S_SWAIT, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    expectState("q_idle", S_IDLE, 1'b0);
    checkOutput("q_ap_done", 32'(bus.ap_done), 32'd1);
    checkOutput("q_ap_ready", 32'(bus.ap_ready), 32'd1);
    checkOutput("q_ap_idle", 32'(bus.ap_idle), 32'd1);
    checkOutput("q_sync_done_off", 32'(bus.sync_done), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("q_ap_done_pulse", 32'(bus.ap_done), 32'd0);
    checkOutput("q_ap_ready_pulse", 32'(bus.ap_ready), 32'd0);
    expectState("q_idle_hold", S_IDLE, 1'b0);

    // Sync round with EXECUTED -> SYNC_EXEC -> LAUNCH
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("e_check", S_CHECK, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("e_sleep", S_SLEEP, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    expectState("e_sync_launch", S_SLNCH, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("e_sync_check", S_SCHK, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("e_sync_exec", S_SEXEC, 1'b0);
    checkOutput("e_sync_exec_out", 32'(bus.sync_exec), 32'd1);
    checkOutput("e_sync_done_out", 32'(bus.sync_done), 32'd1);
    tick();
    expectState("e_sync_exec_hold", S_SEXEC, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    expectState("e_relaunch", S_LAUNCH, 1'b1);
    checkOutput("e_no_ap_done", 32'(bus.ap_done), 32'd0);

    // SYNC_WAIT with another actor progressing -> LAUNCH, no ap_done
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    expectState("p_sync_launch", S_SLNCH, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("p_sync_wait", S_SWAIT, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    expectState("p_relaunch", S_LAUNCH, 1'b1);
    checkOutput("p_no_ap_done", 32'(bus.ap_done), 32'd0);
    checkOutput("p_ap_idle", 32'(bus.ap_idle), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-invocation, then a stray actor_done must be ignored
    ap_rst_n = 1'b0;
    #1;
    expectState("r_async", S_IDLE, 1'b0);
    checkOutput("r_ap_idle", 32'(bus.ap_idle), 32'd1);
    tick();
    ap_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("r_late_done", S_IDLE, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // ap_start held high for a full run; return 7 acts as WAIT
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("h_launch", S_LAUNCH, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("h_check", S_CHECK, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("h_ret7_sleep", S_SLEEP, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    expectState("h_sync_launch", S_SLNCH, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("h_ret7_sync_wait", S_SWAIT, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    expectState("h_idle", S_IDLE, 1'b0);
    checkOutput("h_ap_done", 32'(bus.ap_done), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("h_one_relaunch", S_LAUNCH, 1'b1);
    checkOutput("h_ap_done_off", 32'(bus.ap_done), 32'd0);
    tick();
    expectState("h_launch_hold", S_LAUNCH, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
